round_controller: RTL and testbench

Sequences each Tron round between the game-state FSM and the light-cycle datapath. Runs a frame-timed 3-2-1 countdown, gates cycle motion, scores crash events, holds a post-round pause, and then either pulses `Reset_Round` or raises `Blue_W`/`Red_W` back to the game-state FSM. It sits between the game-state FSM, the collision detector and the cycle movement/trail logic.

---
 rtl/round_controller_if.sv | 28 ++
 rtl/round_controller.sv | 181 ++++++++++++++++++
 tb/tb_round_controller.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/round_controller_if.sv
// Signal bundle between round_controller and the game FSM, collision detector and cycle logic.
// master is the round_controller side; slave is the surrounding game logic.
interface round_controller_if;
  logic       frame_tick;
  logic [2:0] Game_State;
  logic       blue_crash;
  logic       red_crash;
  logic       motion_enable;
  logic       clear_field;
  logic [1:0] countdown;
  logic [3:0] blue_score;
  logic [3:0] red_score;
  logic       Reset_Round;
  logic       Blue_W;
  logic       Red_W;

  modport master (
    input  frame_tick, Game_State, blue_crash, red_crash,
    output motion_enable, clear_field, countdown, blue_score, red_score,
           Reset_Round, Blue_W, Red_W
  );

  modport slave (
    output frame_tick, Game_State, blue_crash, red_crash,
    input  motion_enable, clear_field, countdown, blue_score, red_score,
           Reset_Round, Blue_W, Red_W
  );
endinterface

// File: rtl/round_controller.sv
// Tron round sequencer: frame-timed 3-2-1 countdown, motion gating, crash scoring,
// post-round pause, then either a round restart pulse or a held match-win flag.
module round_controller #(
  parameter int WIN_ROUNDS   = 3,
  parameter int COUNT_FRAMES = 60,
  parameter int END_FRAMES   = 90
) (
  input logic              Clk,
  input logic              Reset_n,
  round_controller_if.master bus
);

  typedef enum logic [2:0] {
    IDLE,
    COUNTDOWN,
    RUNNING,
    ROUND_END,
    MATCH_END
  } state_t;

  localparam logic [2:0] GS_MENU    = 3'd0;
  localparam logic [2:0] GS_STARTED = 3'd2;
  localparam logic [7:0] COUNT_LAST = 8'(COUNT_FRAMES - 1);
  localparam logic [7:0] END_LAST   = 8'(END_FRAMES - 1);
  localparam logic [3:0] WIN_SCORE  = 4'(WIN_ROUNDS);

  state_t     r_state,       w_state_nxt;
  logic [7:0] r_frame_cnt,   w_frame_cnt_nxt;
  logic [1:0] r_countdown,   w_countdown_nxt;
  logic [3:0] r_blue_score,  w_blue_score_nxt;
  logic [3:0] r_red_score,   w_red_score_nxt;
  logic       r_motion,      w_motion_nxt;
  logic       r_clear,       w_clear_nxt;
  logic       r_reset_round, w_reset_round_nxt;
  logic       r_blue_w,      w_blue_w_nxt;
  logic       r_red_w,       w_red_w_nxt;
  logic       w_started;
  logic       w_blue_won;

  assign w_started  = (bus.Game_State == GS_STARTED);
  assign w_blue_won = (r_blue_score == WIN_SCORE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state       <= IDLE;
      r_frame_cnt   <= '0;
      r_countdown   <= '0;
      r_blue_score  <= '0;
      r_red_score   <= '0;
      r_motion      <= 1'b0;
      r_clear       <= 1'b0;
      r_reset_round <= 1'b0;
      r_blue_w      <= 1'b0;
      r_red_w       <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_frame_cnt   <= w_frame_cnt_nxt;
      r_countdown   <= w_countdown_nxt;
      r_blue_score  <= w_blue_score_nxt;
      r_red_score   <= w_red_score_nxt;
      r_motion      <= w_motion_nxt;
      r_clear       <= w_clear_nxt;
      r_reset_round <= w_reset_round_nxt;
      r_blue_w      <= w_blue_w_nxt;
      r_red_w       <= w_red_w_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_frame_cnt_nxt   = r_frame_cnt;
    w_countdown_nxt   = r_countdown;
    w_blue_score_nxt  = r_blue_score;
    w_red_score_nxt   = r_red_score;
    w_motion_nxt      = 1'b0;
    w_clear_nxt       = 1'b0;
    w_reset_round_nxt = 1'b0;
    w_blue_w_nxt      = r_blue_w;
    w_red_w_nxt       = r_red_w;

    case (r_state)
      IDLE: begin
        w_countdown_nxt = 2'd0;
        w_blue_w_nxt    = 1'b0;
        w_red_w_nxt     = 1'b0;
        if (w_started) begin
          w_state_nxt     = COUNTDOWN;
          w_clear_nxt     = 1'b1;
          w_countdown_nxt = 2'd3;
          w_frame_cnt_nxt = 8'd0;
        end
      end

      COUNTDOWN: begin
        if (!w_started) begin
          w_state_nxt     = IDLE;
          w_countdown_nxt = 2'd0;
        end else if (bus.frame_tick) begin
          if (r_frame_cnt == COUNT_LAST) begin
            w_frame_cnt_nxt = 8'd0;
            w_countdown_nxt = r_countdown - 2'd1;
            if (r_countdown == 2'd1) begin
              w_state_nxt  = RUNNING;
              w_motion_nxt = 1'b1;
            end
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + 8'd1;
          end
        end
      end

      // A crash by one cycle scores for the other; a simultaneous crash is a draw.
      RUNNING: begin
        if (!w_started) begin
          w_state_nxt = IDLE;
        end else if (bus.blue_crash || bus.red_crash) begin
          w_state_nxt     = ROUND_END;
          w_frame_cnt_nxt = 8'd0;
          if (bus.blue_crash && !bus.red_crash && r_red_score < WIN_SCORE)
            w_red_score_nxt = r_red_score + 4'd1;
          if (bus.red_crash && !bus.blue_crash && r_blue_score < WIN_SCORE)
            w_blue_score_nxt = r_blue_score + 4'd1;
        end else begin
          w_motion_nxt = 1'b1;
        end
      end

      ROUND_END: begin
        if (!w_started) begin
          w_state_nxt = IDLE;
        end else if (bus.frame_tick) begin
          if (r_frame_cnt == END_LAST) begin
            w_frame_cnt_nxt = 8'd0;
            if (w_blue_won || r_red_score == WIN_SCORE) begin
              w_state_nxt  = MATCH_END;
              w_blue_w_nxt = w_blue_won;
              w_red_w_nxt  = !w_blue_won;
            end else begin
              w_state_nxt       = IDLE;
              w_reset_round_nxt = 1'b1;
            end
          end else begin
            w_frame_cnt_nxt = r_frame_cnt + 8'd1;
          end
        end
      end

      MATCH_END: begin
        if (!w_started) begin
          w_state_nxt  = IDLE;
          w_blue_w_nxt = 1'b0;
          w_red_w_nxt  = 1'b0;
        end
      end

      default: w_state_nxt = IDLE;
    endcase

    if (bus.Game_State == GS_MENU) begin
      w_state_nxt       = IDLE;
      w_blue_score_nxt  = 4'd0;
      w_red_score_nxt   = 4'd0;
      w_countdown_nxt   = 2'd0;
      w_motion_nxt      = 1'b0;
      w_clear_nxt       = 1'b0;
      w_reset_round_nxt = 1'b0;
      w_blue_w_nxt      = 1'b0;
      w_red_w_nxt       = 1'b0;
    end
  end

  assign bus.motion_enable = r_motion;
  assign bus.clear_field   = r_clear;
  assign bus.countdown     = r_countdown;
  assign bus.blue_score    = r_blue_score;
  assign bus.red_score     = r_red_score;
  assign bus.Reset_Round   = r_reset_round;
  assign bus.Blue_W        = r_blue_w;
  assign bus.Red_W         = r_red_w;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller with COUNT_FRAMES=2, END_FRAMES=3, WIN_ROUNDS=2.
module tb_round_controller;

  logic Clk;
  logic Reset_n;
  int   passCount  = 0;
  int   checkCount = 0;

  round_controller_if bus ();

  round_controller #(
    .WIN_ROUNDS  (2),
    .COUNT_FRAMES(2),
    .END_FRAMES  (3)
  ) dut (
    .Clk    (Clk),
    .Reset_n(Reset_n),
    .bus    (bus.master)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Inputs are held across one rising edge; tick and crashes then drop back to 0.
  task automatic applyStimulus(input logic [2:0] gs, input logic tick,
                               input logic bc, input logic rc);
    bus.Game_State = gs;
    bus.frame_tick = tick;
    bus.blue_crash = bc;
    bus.red_crash  = rc;
    @(posedge Clk);
    #1;
    bus.frame_tick = 1'b0;
    bus.blue_crash = 1'b0;
    bus.red_crash  = 1'b0;
  endtask

  task automatic runTicks(input int n);
    for (int i = 0; i < n; i++) applyStimulus(3'd2, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checkCount++;
    assert (observed === expected) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    Reset_n        = 1'b0;
    bus.Game_State = 3'd0;
    bus.frame_tick = 1'b0;
    bus.blue_crash = 1'b0;
    bus.red_crash  = 1'b0;
    #12;
    checkOutput("rst_motion", 8'(bus.motion_enable), 8'd0);
    checkOutput("rst_countdown", 8'(bus.countdown), 8'd0);
    checkOutput("rst_scores", {bus.blue_score, bus.red_score}, 8'd0);
    checkOutput("rst_flags", {5'd0, bus.Reset_Round, bus.Blue_W, bus.Red_W}, 8'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] countdown");
    applyStimulus(3'd2, 1'b0, 1'b0, 1'b0);
    checkOutput("cd_clear_on", 8'(bus.clear_field), 8'd1);
    checkOutput("cd_three", 8'(bus.countdown), 8'd3);
    runTicks(1);
    checkOutput("cd_clear_off", 8'(bus.clear_field), 8'd0);
    checkOutput("cd_still3", 8'(bus.countdown), 8'd3);
    runTicks(1);
    checkOutput("cd_two", 8'(bus.countdown), 8'd2);
    applyStimulus(3'd2, 1'b0, 1'b0, 1'b0);
    checkOutput("cd_no_tick_hold", 8'(bus.countdown), 8'd2);
    runTicks(2);
    checkOutput("cd_one", 8'(bus.countdown), 8'd1);
    runTicks(1);
    checkOutput("cd_motion_pre", 8'(bus.motion_enable), 8'd0);
    runTicks(1);
    checkOutput("cd_motion_on", 8'(bus.motion_enable), 8'd1);
    checkOutput("cd_zero", 8'(bus.countdown), 8'd0);

    $display("[TB] single crash");
    applyStimulus(3'd2, 1'b0, 1'b0, 1'b1);
    checkOutput("sc_blue_score", 8'(bus.blue_score), 8'd1);
    checkOutput("sc_red_score", 8'(bus.red_score), 8'd0);
    checkOutput("sc_motion_off", 8'(bus.motion_enable), 8'd0);
    runTicks(2);
    checkOutput("sc_rr_early", 8'(bus.Reset_Round), 8'd0);
    runTicks(1);
    checkOutput("sc_rr_pulse", 8'(bus.Reset_Round), 8'd1);
    applyStimulus(3'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("sc_rr_single", 8'(bus.Reset_Round), 8'd0);
    checkOutput("sc_idle_cd", 8'(bus.countdown), 8'd0);

    $display("[TB] draw");
    applyStimulus(3'd2, 1'b0, 1'b0, 1'b0);
    checkOutput("dr_clear", 8'(bus.clear_field), 8'd1);
    runTicks(6);
    checkOutput("dr_motion_on", 8'(bus.motion_enable), 8'd1);
    applyStimulus(3'd2, 1'b0, 1'b1, 1'b1);
    checkOutput("dr_scores", {bus.blue_score, bus.red_score}, 8'h10);
    checkOutput("dr_motion_off", 8'(bus.motion_enable), 8'd0);
    applyStimulus(3'd2, 1'b1, 1'b1, 1'b0);
    checkOutput("dr_late_crash_ignored", {bus.blue_score, bus.red_score}, 8'h10);
    runTicks(1);
    checkOutput("dr_rr_early", 8'(bus.Reset_Round), 8'd0);
    runTicks(1);
    checkOutput("dr_rr_pulse", 8'(bus.Reset_Round), 8'd1);
    applyStimulus(3'd1, 1'b0, 1'b0, 1'b0);

    $display("[TB] match win");
    applyStimulus(3'd2, 1'b0, 1'b0, 1'b0);
    runTicks(6);
    applyStimulus(3'd2, 1'b0, 1'b1, 1'b0);
    checkOutput("mw_red1", 8'(bus.red_score), 8'd1);
    runTicks(3);
    checkOutput("mw_rr1", 8'(bus.Reset_Round), 8'd1);
    applyStimulus(3'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd2, 1'b0, 1'b0, 1'b0);
    runTicks(6);
    applyStimulus(3'd2, 1'b0, 1'b1, 1'b0);
    checkOutput("mw_red2", 8'(bus.red_score), 8'd2);
    runTicks(2);
    checkOutput("mw_redw_early", 8'(bus.Red_W), 8'd0);
    runTicks(1);
    checkOutput("mw_redw_on", 8'(bus.Red_W), 8'd1);
    checkOutput("mw_bluew_off", 8'(bus.Blue_W), 8'd0);
    checkOutput("mw_no_rr", 8'(bus.Reset_Round), 8'd0);
    applyStimulus(3'd2, 1'b1, 1'b0, 1'b0);
    checkOutput("mw_redw_held", 8'(bus.Red_W), 8'd1);
    applyStimulus(3'd4, 1'b0, 1'b0, 1'b0);
    checkOutput("mw_redw_drop", {bus.Blue_W, bus.Red_W}, 8'd0);

    $display("[TB] abort");
    applyStimulus(3'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd2, 1'b0, 1'b0, 1'b0);
    runTicks(6);
    checkOutput("ab_motion_on", 8'(bus.motion_enable), 8'd1);
    applyStimulus(3'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("ab_motion_off", 8'(bus.motion_enable), 8'd0);
    checkOutput("ab_scores_kept", {bus.blue_score, bus.red_score}, 8'h12);
    checkOutput("ab_no_rr", 8'(bus.Reset_Round), 8'd0);
    applyStimulus(3'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("ab_stays_idle", 8'(bus.clear_field), 8'd0);
    applyStimulus(3'd2, 1'b0, 1'b0, 1'b0);
    checkOutput("ab_restart", 8'(bus.countdown), 8'd3);
    runTicks(6);
    applyStimulus(3'd0, 1'b0, 1'b1, 1'b0);
    checkOutput("ab_menu_crash_scores", {bus.blue_score, bus.red_score}, 8'h00);
    checkOutput("ab_menu_motion", 8'(bus.motion_enable), 8'd0);
    applyStimulus(3'd0, 1'b0, 1'b0, 1'b0);

    $display("[TB] async reset");
    applyStimulus(3'd2, 1'b0, 1'b0, 1'b0);
    runTicks(1);
    checkOutput("ar_pre_cd", 8'(bus.countdown), 8'd3);
    #3;
    Reset_n = 1'b0;
    #1;
    checkOutput("ar_cd_zero", 8'(bus.countdown), 8'd0);
    checkOutput("ar_flags_zero",
                {4'd0, bus.clear_field, bus.motion_enable, bus.Reset_Round, bus.Red_W}, 8'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    applyStimulus(3'd1, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("ar_idle_cd", 8'(bus.countdown), 8'd0);
    checkOutput("ar_idle_clear", 8'(bus.clear_field), 8'd0);
    applyStimulus(3'd2, 1'b0, 1'b0, 1'b0);
    checkOutput("ar_start_clear", 8'(bus.clear_field), 8'd1);
    checkOutput("ar_start_cd", 8'(bus.countdown), 8'd3);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
